// File: rtl/sdpram_pkg.sv
// rtl/sdpram_pkg.sv - shared types, limits and byte-lane merge for the sdpram family
package sdpram_pkg;

  typedef enum logic {ST_INIT, ST_READY} sdpram_state_e;

  localparam int MAX_R_LATENCY = 4;
  // Widest word the shared merge helper handles; narrower callers zero-extend.
  localparam int MAX_DATA_W    = 1024;

  // Byte-lane merge: lanes with be[i]=1 come from new_w, the rest from old_w.
  function automatic logic [MAX_DATA_W-1:0] be_merge(
    input logic [MAX_DATA_W-1:0]   old_w,
    input logic [MAX_DATA_W-1:0]   new_w,
    input logic [MAX_DATA_W/8-1:0] be
  );
    logic [MAX_DATA_W-1:0] r;
    r = old_w;
    for (int i = 0; i < MAX_DATA_W/8; i++) begin
      if (be[i]) r[8*i +: 8] = new_w[8*i +: 8];
    end
    return r;
  endfunction

endpackage

// File: rtl/sdpram_rd_pipe.sv
// rtl/sdpram_rd_pipe.sv - data+valid shift pipeline for read stages 2..R_LATENCY
module sdpram_rd_pipe #(
  parameter int WIDTH  = 64,
  parameter int STAGES = 1
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_vld,
  output logic [WIDTH-1:0] out_data,
  output logic             out_vld
);

  if (STAGES == 0) begin : g_bypass
    assign out_data = in_data;
    assign out_vld  = in_vld;
  end else begin : g_pipe
    logic [STAGES-1:0] vld;
    logic [WIDTH-1:0]  tail_q;
    logic [WIDTH-1:0]  tail_in;
    logic              tail_en;

    if (STAGES == 1) begin : g_direct
      assign tail_in = in_data;
      assign tail_en = in_vld;
    end else begin : g_mid
      logic [WIDTH-1:0] mid [STAGES-1];

      // Intermediate data moves only behind a valid, so idle cycles never disturb it
      always_ff @(posedge clk) begin
        if (in_vld) mid[0] <= in_data;
        for (int i = 1; i < STAGES-1; i++) begin
          if (vld[i-1]) mid[i] <= mid[i-1];
        end
      end

      assign tail_in = mid[STAGES-2];
      assign tail_en = vld[STAGES-2];
    end

    // Valid shift chain; reset drops every read in flight
    always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
        vld <= '0;
      end else begin
        vld[0] <= in_vld;
        for (int i = 1; i < STAGES; i++) vld[i] <= vld[i-1];
      end
    end

    // Output register: loads only with a valid word so q holds between reads
    always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n)     tail_q <= '0;
      else if (tail_en) tail_q <= tail_in;
    end

    assign out_data = tail_q;
    assign out_vld  = vld[STAGES-1];
  end

endmodule

// File: rtl/sdpram_be_init.sv
// rtl/sdpram_be_init.sv - byte-enable simple dual-port RAM with clear sweep; SDPRAM_WR_FWD_EN enables write-first forwarding
module sdpram_be_init
  import sdpram_pkg::*;
#(
  parameter int                   RAM_DEEP  = 10,
  parameter int                   RAM_WIDTH = 64,
  parameter int                   R_LATENCY = 2,
  parameter int                   INIT_EN   = 1,
  parameter logic [RAM_WIDTH-1:0] INIT_VAL  = '0
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic                   wren,
  input  logic [RAM_DEEP-1:0]    wraddress,
  input  logic [RAM_WIDTH/8-1:0] wrbe,
  input  logic [RAM_WIDTH-1:0]   data,
  input  logic                   rden,
  input  logic [RAM_DEEP-1:0]    rdaddress,
  output logic [RAM_WIDTH-1:0]   q,
  output logic                   q_vld,
  output logic                   init_done
);

  localparam int WORDS = 2**RAM_DEEP;
  localparam sdpram_state_e RESET_STATE = (INIT_EN != 0) ? ST_INIT : ST_READY;

  if ((RAM_WIDTH % 8) != 0 || RAM_WIDTH > MAX_DATA_W) begin : g_bad_width
    $error("sdpram_be_init: RAM_WIDTH must be a multiple of 8 and at most MAX_DATA_W");
  end
  if (R_LATENCY < 1 || R_LATENCY > MAX_R_LATENCY) begin : g_bad_latency
    $error("sdpram_be_init: R_LATENCY must be in 1..MAX_R_LATENCY");
  end

  logic [RAM_WIDTH-1:0] mem [WORDS];

  sdpram_state_e        state_q, state_d;
  logic [RAM_DEEP:0]    init_cnt_q, init_cnt_d;
  logic                 init_done_q;
  logic                 init_wr;
  logic                 wr_fire;
  logic                 rd_fire;
  logic [RAM_WIDTH-1:0] wr_word;
  logic [RAM_WIDTH-1:0] rd_word;
  logic                 s1_vld;
  logic [RAM_WIDTH-1:0] s1_data;

  // Sweep FSM: one clear write per cycle; the extra counter bit flags the last address
  always_comb begin
    state_d    = state_q;
    init_cnt_d = init_cnt_q;
    init_wr    = 1'b0;
    if (state_q == ST_INIT) begin
      init_wr    = 1'b1;
      init_cnt_d = init_cnt_q + {{RAM_DEEP{1'b0}}, 1'b1};
      if (init_cnt_d[RAM_DEEP]) state_d = ST_READY;
    end
  end

  // State, counter and ready flag; init_done follows the edge that enters ST_READY
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= RESET_STATE;
      init_cnt_q  <= '0;
      init_done_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      init_cnt_q  <= init_cnt_d;
      init_done_q <= (state_d == ST_READY);
    end
  end

  assign wr_fire = init_done_q & wren & (|wrbe);
  assign rd_fire = init_done_q & rden;

  // Merged word for a partial write; also the forwarded value on an address hit
  always_comb begin
    wr_word = RAM_WIDTH'(be_merge(MAX_DATA_W'(mem[wraddress]),
                                  MAX_DATA_W'(data),
                                  (MAX_DATA_W/8)'(wrbe)));
  end

`ifdef SDPRAM_WR_FWD_EN
  assign rd_word = (wr_fire && (wraddress == rdaddress)) ? wr_word : mem[rdaddress];
`else
  assign rd_word = mem[rdaddress];
`endif

  // Array write port: clear sweep has priority, user writes only once ready
  always_ff @(posedge clk) begin
    if (init_wr)      mem[init_cnt_q[RAM_DEEP-1:0]] <= INIT_VAL;
    else if (wr_fire) mem[wraddress]                <= wr_word;
  end

  // Stage-1 capture; later writes cannot reach data already captured here
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      s1_vld  <= 1'b0;
      s1_data <= '0;
    end else begin
      s1_vld <= rd_fire;
      if (rd_fire) s1_data <= rd_word;
    end
  end

  sdpram_rd_pipe #(
    .WIDTH  (RAM_WIDTH),
    .STAGES (R_LATENCY - 1)
  ) u_rd_pipe (
    .clk      (clk),
    .reset_n  (reset_n),
    .in_data  (s1_data),
    .in_vld   (s1_vld),
    .out_data (q),
    .out_vld  (q_vld)
  );

  assign init_done = init_done_q;

endmodule

// File: tb/tb_sdpram_be_init.sv
// tb/tb_sdpram_be_init.sv - scoreboard bench for sdpram_be_init (4-bit address, 32-bit data, latency 3)
module tb_sdpram_be_init;

  localparam int          AW = 4;
  localparam int          DW = 32;
  localparam int          L  = 3;
  localparam logic [31:0] IV = 32'hA5A5A5A5;

  logic          clk = 1'b0;
  logic          reset_n;
  logic          wren;
  logic [AW-1:0] wraddress;
  logic [3:0]    wrbe;
  logic [DW-1:0] data;
  logic          rden;
  logic [AW-1:0] rdaddress;
  logic [DW-1:0] q;
  logic          q_vld;
  logic          init_done;

  typedef struct {
    logic [31:0] d;
    int          due;
  } exp_t;

  exp_t        sb [$];
  logic [31:0] model [16];
  int          cyc = 0;
  int          checks = 0;
  int          failures = 0;
  bit          bench_ready = 1'b0;
  int          n;

  sdpram_be_init #(
    .RAM_DEEP  (AW),
    .RAM_WIDTH (DW),
    .R_LATENCY (L),
    .INIT_EN   (1),
    .INIT_VAL  (IV)
  ) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .wren      (wren),
    .wraddress (wraddress),
    .wrbe      (wrbe),
    .data      (data),
    .rden      (rden),
    .rdaddress (rdaddress),
    .q         (q),
    .q_vld     (q_vld),
    .init_done (init_done)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  function automatic logic [31:0] merge(input logic [31:0] o, input logic [31:0] nw, input logic [3:0] be);
    for (int i = 0; i < 4; i++) begin
      if (be[i]) o[8*i +: 8] = nw[8*i +: 8];
    end
    return o;
  endfunction

  // Drive one cycle of stimulus; reads push their expected word and due cycle
  task automatic cyc_op(input logic we, input logic [3:0] wa, input logic [3:0] be,
                        input logic [31:0] d, input logic re, input logic [3:0] ra);
    exp_t e;
    wren = we; wraddress = wa; wrbe = be; data = d;
    rden = re; rdaddress = ra;
    if (re && bench_ready) begin
      e.d = model[ra];
`ifdef SDPRAM_WR_FWD_EN
      if (we && wa == ra) e.d = merge(e.d, d, be);
`endif
      e.due = cyc + L;
      sb.push_back(e);
    end
    @(posedge clk);
    #1;
    if (we && bench_ready) model[wa] = merge(model[wa], d, be);
    wren = 1'b0;
    rden = 1'b0;
  endtask

  task automatic flush();
    int k;
    k = 0;
    while (sb.size() > 0 && k < 20) begin
      @(posedge clk);
      #1;
      k++;
    end
    if (sb.size() > 0) begin
      check("flush_timeout", 64'(sb.size()), 64'd0);
      sb.delete();
    end
  endtask

  // Count cycles with init_done low; optionally hammer wren/rden during the sweep
  task automatic wait_init(input bit poke, output int cnt);
    cnt = 0;
    while (cnt < 100) begin
      @(negedge clk);
      if (init_done) break;
      cnt++;
      if (poke) begin
        wren = 1'b1; wraddress = cnt[3:0]; wrbe = 4'hF; data = 32'hDEADBEEF;
        rden = 1'b1; rdaddress = cnt[3:0];
      end
    end
    wren = 1'b0;
    rden = 1'b0;
  endtask

  // Output monitor: every q_vld must match the oldest expected read at its due cycle
  always @(negedge clk) begin
    exp_t e;
    if (reset_n) begin
      if (sb.size() > 0 && sb[0].due < cyc) begin
        check("missing_vld", 64'd0, 64'd1);
        void'(sb.pop_front());
      end
      if (q_vld) begin
        if (sb.size() == 0) begin
          check("spurious_vld", 64'd1, 64'd0);
        end else begin
          e = sb.pop_front();
          check("q_cycle", 64'(cyc), 64'(e.due));
          check("q_data", 64'(q), 64'(e.d));
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset_n = 1'b0;
    wren = 1'b0; wraddress = '0; wrbe = '0; data = '0;
    rden = 1'b0; rdaddress = '0;
    for (int i = 0; i < 16; i++) model[i] = IV;

    // Reset state and clear sweep length
    repeat (3) @(posedge clk);
    #1;
    check("rst_q", 64'(q), 64'd0);
    check("rst_q_vld", 64'(q_vld), 64'd0);
    check("rst_init_done", 64'(init_done), 64'd0);
    reset_n = 1'b1;
    wait_init(1'b0, n);
    check("init_len", 64'(n), 64'd16);
    bench_ready = 1'b1;
    for (int a = 0; a < 16; a++) cyc_op(1'b0, 4'd0, 4'd0, 32'd0, 1'b1, 4'(a));
    flush();

    // Full then partial byte write
    cyc_op(1'b1, 4'd3, 4'hF, 32'h11223344, 1'b0, 4'd0);
    cyc_op(1'b1, 4'd3, 4'b0101, 32'hDDCCBBAA, 1'b0, 4'd0);
    cyc_op(1'b0, 4'd0, 4'd0, 32'd0, 1'b1, 4'd3);
    flush();

    // Back-to-back reads of distinct words
    for (int i = 0; i < 8; i++) cyc_op(1'b1, 4'(i), 4'hF, 32'h10000000 + 32'h01010101 * i, 1'b0, 4'd0);
    for (int i = 0; i < 8; i++) cyc_op(1'b0, 4'd0, 4'd0, 32'd0, 1'b1, 4'(i));
    flush();

    // Same-cycle read and write to one address, then a follow-up read
    cyc_op(1'b1, 4'd5, 4'hF, 32'h00000000, 1'b0, 4'd0);
    cyc_op(1'b1, 4'd5, 4'b0011, 32'hFFFFFFFF, 1'b1, 4'd5);
    cyc_op(1'b0, 4'd0, 4'd0, 32'd0, 1'b1, 4'd5);
    flush();

    // Zero byte-enable write is a no-op
    cyc_op(1'b1, 4'd7, 4'h0, 32'h12345678, 1'b0, 4'd0);
    cyc_op(1'b0, 4'd0, 4'd0, 32'd0, 1'b1, 4'd7);
    flush();

    // Reset with two reads in flight while ready
    cyc_op(1'b0, 4'd0, 4'd0, 32'd0, 1'b1, 4'd3);
    cyc_op(1'b0, 4'd0, 4'd0, 32'd0, 1'b1, 4'd5);
    reset_n = 1'b0;
    sb.delete();
    bench_ready = 1'b0;
    #1;
    check("rst_fly_q_vld", 64'(q_vld), 64'd0);
    check("rst_fly_q", 64'(q), 64'd0);
    repeat (3) begin
      @(negedge clk);
      check("rst_hold_q_vld", 64'(q_vld), 64'd0);
    end
    @(posedge clk);
    #1;
    reset_n = 1'b1;

    // Reset again mid-sweep; sweep must restart from address 0
    repeat (5) @(posedge clk);
    #1;
    reset_n = 1'b0;
    #1;
    check("rst_sweep_done", 64'(init_done), 64'd0);
    @(posedge clk);
    #1;
    reset_n = 1'b1;
    wait_init(1'b1, n);
    check("reinit_len", 64'(n), 64'd16);
    for (int i = 0; i < 16; i++) model[i] = IV;
    bench_ready = 1'b1;
    for (int a = 0; a < 16; a++) cyc_op(1'b0, 4'd0, 4'd0, 32'd0, 1'b1, 4'(a));
    flush();
    repeat (4) @(posedge clk);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
